osf_ob_fifo_rdr: RTL and testbench

Output-side reader for the OSF outbound data FIFO. The debug-FIFO control path writes this FIFO under almost-full flow control; this block drains it. It issues FIFO reads under credit control, absorbs the 1-cycle FIFO read latency in a 2-entry skid buffer, and presents the beats as an AXI4-Stream master toward the egress interface. It also provides a frame-boundary debug hold and frame/beat counters for status registers.

---
 rtl/osf_ob_fifo_rdr.sv | 143 ++++++++++++++
 tb/tb_osf_ob_fifo_rdr.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osf_ob_fifo_rdr.sv
// osf_ob_fifo_rdr
// Drains the OSF outbound data FIFO and presents its beats as an AXI4-Stream master.
// FIFO reads are issued under credit control, and the 1-cycle FIFO read latency is absorbed
// in a 2-entry skid buffer. A debug hold stops draining at the next frame boundary.
// Frame and beat counters are provided for status registers.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   hold              debug hold request (takes effect at the next frame boundary)
//   fifo_empty        FIFO empty flag (registered; lags a read issued in the previous cycle)
//   fifo_aempty       FIFO depth <= 1 (same timing as fifo_empty)
//   fifo_rd           FIFO read strobe
//   fifo_rdata        {tlast, tuser, tdata}; valid the cycle after fifo_rd
//   m_t*              AXI4-Stream master (tvalid/tready/tdata/tuser/tlast)
//   frame_cnt         frames transferred (wraps)
//   beat_cnt          beats in the current frame (saturates)
//   idle              held and fully drained
module osf_ob_fifo_rdr #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned USER_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   hold,
   input  logic                   fifo_empty,
   input  logic                   fifo_aempty,
   output logic                   fifo_rd,
   input  logic [DATA_W+USER_W:0] fifo_rdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [DATA_W-1:0]      m_tdata,
   output logic [USER_W-1:0]      m_tuser,
   output logic                   m_tlast,
   output logic [15:0]            frame_cnt,
   output logic [15:0]            beat_cnt,
   output logic                   idle
);

   localparam int unsigned EntW = DATA_W + USER_W + 1;

   typedef enum logic [1:0] {StRun, StDrain, StHeld} state_e;

   state_e          state_q, state_d;
   logic [EntW-1:0] skid_q [2];
   logic            rd_ptr_q, wr_ptr_q;
   logic [1:0]      occ_q, occ_d;
   logic            inflight_q;
   logic            mid_frame_q;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic [15:0]     beat_cnt_q, beat_cnt_d;

   logic            pop, push;
   logic            credit_ok, rd_ok, rd_en;
   logic [EntW-1:0] head;

   assign pop  = m_tvalid & m_tready;
   assign push = inflight_q;

   // occ + inflight - pop < 2, with pop moved to the right-hand side to avoid underflow
   assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
   // The empty flag does not yet see last cycle's read, so a back-to-back read needs depth >= 2
   assign rd_ok     = credit_ok & ~fifo_empty & (~inflight_q | ~fifo_aempty);

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      unique case (state_q)
         StRun: begin
            rd_en = rd_ok;
            if (hold) state_d = StDrain;
         end
         StDrain: begin
            // One beat outstanding at a time, and only while the current frame is still open,
            // so the last read issued is the tlast beat.
            rd_en = rd_ok & ~inflight_q & mid_frame_q;
            if (!hold) begin
               state_d = StRun;
            end else if (!mid_frame_q && !inflight_q) begin
               state_d = StHeld;
            end
         end
         StHeld: begin
            if (!hold) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   // Gated by reset so no read strobe escapes while the block is held in reset
   assign fifo_rd = rd_en & rst_n;

   assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      if (pop) begin
         if (m_tlast) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            beat_cnt_d  = 16'd0;
         end else if (beat_cnt_q != 16'hFFFF) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         skid_q[0]   <= '0;
         skid_q[1]   <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         occ_q       <= 2'd0;
         inflight_q  <= 1'b0;
         mid_frame_q <= 1'b0;
         frame_cnt_q <= 16'd0;
         beat_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         inflight_q  <= rd_en;
         occ_q       <= occ_d;
         frame_cnt_q <= frame_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         if (push) begin
            skid_q[wr_ptr_q] <= fifo_rdata;
            wr_ptr_q         <= ~wr_ptr_q;
            mid_frame_q      <= ~fifo_rdata[EntW-1];
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   assign head      = skid_q[rd_ptr_q];
   assign m_tvalid  = (occ_q != 2'd0);
   assign m_tdata   = head[DATA_W-1:0];
   assign m_tuser   = head[DATA_W +: USER_W];
   assign m_tlast   = head[EntW-1];
   assign frame_cnt = frame_cnt_q;
   assign beat_cnt  = beat_cnt_q;
   assign idle      = (state_q == StHeld) & (occ_q == 2'd0) & ~inflight_q;

endmodule

// File: tb/tb_osf_ob_fifo_rdr.sv
// Bench for osf_ob_fifo_rdr: a FIFO model with lagging empty/aempty flags feeds the DUT.
// Every beat loaded into the FIFO is also queued as an expected stream beat; a negedge
// monitor pops and compares on each handshake and checks AXI stability and credit limits.
module tb_osf_ob_fifo_rdr;

   localparam int DATA_W = 64;
   localparam int USER_W = 8;
   localparam int ENT_W  = DATA_W + USER_W + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              hold = 1'b0;
   logic              fifo_empty = 1'b1;
   logic              fifo_aempty = 1'b1;
   logic              fifo_rd;
   logic [ENT_W-1:0]  fifo_rdata = '0;
   logic              m_tvalid;
   logic              m_tready = 1'b0;
   logic [DATA_W-1:0] m_tdata;
   logic [USER_W-1:0] m_tuser;
   logic              m_tlast;
   logic [15:0]       frame_cnt;
   logic [15:0]       beat_cnt;
   logic              idle;

   osf_ob_fifo_rdr #(.DATA_W(DATA_W), .USER_W(USER_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hold       (hold),
      .fifo_empty (fifo_empty),
      .fifo_aempty(fifo_aempty),
      .fifo_rd    (fifo_rd),
      .fifo_rdata (fifo_rdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tdata    (m_tdata),
      .m_tuser    (m_tuser),
      .m_tlast    (m_tlast),
      .frame_cnt  (frame_cnt),
      .beat_cnt   (beat_cnt),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   logic [ENT_W-1:0] fifo_mem[$];
   logic [ENT_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int rd_total = 0;
   int pop_total = 0;
   int drop_total = 0;
   int first_rd_cyc = -1;
   int last_rd_cyc = -1;
   int first_vld_cyc = -1;
   int cnt_pre;

   function automatic void chk(input string name, input logic [ENT_W-1:0] act,
                               input logic [ENT_W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endfunction

   function automatic void chk_int(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   function automatic logic [ENT_W-1:0] mk(input logic [7:0] id, input logic last);
      return {last, id, 56'hA5A5_0000_0000_00, id};
   endfunction

   // Beats go to the FIFO and, in the same order, to the expected stream
   task automatic load(input logic [7:0] id0, input int n, input logic last_on_end);
      for (int i = 0; i < n; i++) begin
         logic [ENT_W-1:0] b;
         b = mk(id0 + 8'(i), last_on_end && (i == n - 1));
         fifo_mem.push_back(b);
         exp_q.push_back(b);
      end
   endtask

   task automatic wait_drain(input string name, input int max_cyc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: timeout with %0d beats outstanding, expected 0", name, exp_q.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string name);
      chk_int({name, "_fifo_rd"}, int'(fifo_rd), 0);
      chk_int({name, "_tvalid"}, int'(m_tvalid), 0);
      chk({name, "_tdata"}, ENT_W'(m_tdata), '0);
      chk_int({name, "_tuser"}, int'(m_tuser), 0);
      chk_int({name, "_tlast"}, int'(m_tlast), 0);
      chk_int({name, "_frame_cnt"}, int'(frame_cnt), 0);
      chk_int({name, "_beat_cnt"}, int'(beat_cnt), 0);
      chk_int({name, "_idle"}, int'(idle), 0);
   endtask

   // FIFO model: flags registered from the pre-read depth, so they lag a read by one cycle
   always @(posedge clk) begin
      cyc <= cyc + 1;
      cnt_pre = fifo_mem.size();
      fifo_empty  <= (cnt_pre == 0);
      fifo_aempty <= (cnt_pre <= 1);
      if (fifo_rd) begin
         chk_int("rd_when_empty", int'(cnt_pre != 0), 1);
         if (cnt_pre != 0) begin
            fifo_rdata <= fifo_mem.pop_front();
            rd_total++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
         end
      end
   end

   logic [ENT_W-1:0] prev_beat = '0;
   logic             prev_stall = 1'b0;
   logic [ENT_W-1:0] cur_beat;

   always @(negedge clk) begin
      cur_beat = {m_tlast, m_tuser, m_tdata};
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk_int("stall_tvalid", int'(m_tvalid), 1);
            chk("stall_payload", cur_beat, prev_beat);
         end
         if (m_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (m_tvalid && m_tready) begin
            pop_total++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL beat: got unexpected %0h, expected no beat", cur_beat);
            end else begin
               chk("beat", cur_beat, exp_q.pop_front());
            end
         end
         if (m_tvalid && !m_tready) begin
            chk_int("outstanding_le2", int'((rd_total - pop_total - drop_total) <= 2), 1);
         end
         prev_stall = m_tvalid & ~m_tready;
         prev_beat  = cur_beat;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      int drop_n;

      // Streaming at full rate, including reset values with a non-empty FIFO
      m_tready = 1'b1;
      load(8'h10, 8, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      rst_n = 1'b1;
      wait_drain("t1_drain", 50);
      chk_int("t1_rd_count", rd_total, 8);
      chk_int("t1_rd_span", last_rd_cyc - first_rd_cyc, 7);
      chk_int("t1_vld_latency", first_vld_cyc - first_rd_cyc, 2);
      chk_int("t1_frame_cnt", int'(frame_cnt), 1);
      chk_int("t1_beat_cnt", int'(beat_cnt), 0);

      // Toggling ready: the monitor checks order, stability and credit limits
      load(8'h20, 8, 1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         #1;
         m_tready = ~m_tready;
         n++;
      end
      m_tready = 1'b1;
      wait_drain("t2_drain", 20);
      chk_int("t2_frame_cnt", int'(frame_cnt), 2);
      chk_int("t2_beat_cnt", int'(beat_cnt), 0);

      // Hold raised while beat 3 of a 6-beat frame is on the output, second frame queued
      base = rd_total;
      load(8'h30, 6, 1'b1);
      load(8'h40, 6, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      hold = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk_int("t3_idle", int'(idle), 1);
      chk_int("t3_reads_frame1", rd_total - base, 6);
      chk_int("t3_frame2_pending", exp_q.size(), 6);
      chk_int("t3_frame_cnt_held", int'(frame_cnt), 3);
      hold = 1'b0;
      chk_int("t3_no_rd_on_release", int'(fifo_rd), 0);
      wait_drain("t3_drain", 40);
      chk_int("t3_frame_cnt", int'(frame_cnt), 4);

      // Depth 1: the stale empty flag must not cause a second read
      load(8'h50, 1, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fifo_rd && n < 10);
      chk_int("t4_rd_seen", int'(fifo_rd), 1);
      @(negedge clk);
      chk_int("t4_no_b2b_rd", int'(fifo_rd), 0);
      wait_drain("t4_drain", 20);
      chk_int("t4_frame_cnt", int'(frame_cnt), 5);

      // Counter wrap and saturation, preloaded by force
      force dut.frame_cnt_q = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.frame_cnt_q;
      load(8'h58, 1, 1'b1);
      wait_drain("t5a_drain", 20);
      chk_int("t5_frame_wrap", int'(frame_cnt), 0);
      force dut.beat_cnt_q = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.beat_cnt_q;
      load(8'h60, 4, 1'b0);
      wait_drain("t5b_drain", 20);
      chk_int("t5_beat_sat", int'(beat_cnt), 16'hFFFF);
      load(8'h64, 1, 1'b1);
      wait_drain("t5c_drain", 20);
      chk_int("t5_beat_clear", int'(beat_cnt), 0);
      chk_int("t5_frame_cnt", int'(frame_cnt), 1);

      // Reset with one beat buffered and one in flight under backpressure
      m_tready = 1'b0;
      load(8'h70, 4, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk_int("t6_outstanding", rd_total - pop_total - drop_total, 2);
      rst_n = 1'b0;
      drop_n = rd_total - pop_total - drop_total;
      drop_total += drop_n;
      for (int i = 0; i < drop_n; i++) void'(exp_q.pop_front());
      #1;
      check_reset("t6_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_tready = 1'b1;
      wait_drain("t6_drain", 20);
      chk_int("t6_frame_cnt", int'(frame_cnt), 1);
      chk_int("t6_beat_cnt", int'(beat_cnt), 0);

      chk_int("exp_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
